queue_ctrl: RTL and testbench
=============================

Name: queue_ctrl

Overview:
Occupancy controller for the bank queue. Conditions the back (arrival) and front (departure) photocell sensors and keeps the queued-person count (0..7). Holds the active teller count (1..3) and builds the 5-bit wait-time ROM index {tcount, pcount}. Drives the external combinational wait-time ROM and registers its returned value as the displayed wait time.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples needed before a sensor's debounced level changes (range 1..255)
TCOUNT_RST, 1, teller count loaded at reset (1..3)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
back_sensor  in  1  raw, asynchronous; 1 = beam blocked at queue entry
front_sensor  in  1  raw, asynchronous; 1 = beam blocked at queue exit (teller side)
tcount_in  in  2  requested teller count
tcount_load  in  1  one-cycle strobe; capture tcount_in
wtime_rom  in  5  wait-time value returned by the ROM for index_rom
index_rom  out  5  ROM address = {tcount, pcount}
pcount  out  3  people in queue
tcount  out  2  active tellers
wtime  out  5  registered wait time
full  out  1  pcount == 7
empty  out  1  pcount == 0
arr_drop  out  1  one-cycle pulse: arrival ignored because queue full
dep_err  out  1  one-cycle pulse: departure ignored because queue empty

Behaviour:
- Reset values (async assert): pcount=0, tcount=TCOUNT_RST, wtime=0, arr_drop=0, dep_err=0, sync and debounce flops=0, debounce counters=0, edge-detect history=0. Result: empty=1, full=0, index_rom={TCOUNT_RST,3'b000}.
- Reset mid-count or mid-debounce discards all in-flight sensor events. Deassert is synchronous to clk.
- Per-sensor conditioning path:
  - 2-FF synchronizer feeds the debouncer.
  - Debouncer: when the sync output equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - Net effect: the debounced level changes DEB_CYCLES cycles after the sync output first differs, i.e. DEB_CYCLES+2 cycles after the raw change. Glitches shorter than DEB_CYCLES are rejected.
- Events:
  - arrival = debounced back_sensor falling edge (person has passed the beam).
  - departure = debounced front_sensor falling edge.
  - Each event is a single-cycle pulse.
- pcount update, registered, applied the cycle after the event pulse:
  - arrival only: if pcount<7 then +1, else hold and pulse arr_drop.
  - departure only: if pcount>0 then -1, else hold and pulse dep_err.
  - both in the same cycle: pcount unchanged, no error pulses, including at pcount=0 and pcount=7.
  - neither: hold.
  - pcount never wraps.
- tcount:
  - On tcount_load with tcount_in in 1..3, tcount takes tcount_in next cycle.
  - tcount_in=0 is ignored; tcount holds.
  - A load in the same cycle as a pcount update applies both.
- index_rom: combinational {tcount, pcount} from registers.
- wtime:
  - Registered every cycle: wtime <= wtime_rom, so it lags index_rom by one cycle.
  - wtime_rom is expected to return 0 for pcount=0, so an empty queue shows 0.
- full and empty are combinational from pcount.
- Latency: raw sensor fall to pcount change = DEB_CYCLES+3 cycles; pcount change to wtime change = 1 cycle.

Test Plan:
- Reset, tcount_load=0, ROM model attached -> pcount=0, tcount=1, index_rom=5'b01000, wtime=0, empty=1.
- back_sensor pulse high 10 cycles then low, DEB_CYCLES=4 -> pcount=1 exactly 7 cycles after the raw fall; index_rom=5'b01001; wtime=3 one cycle later.
- 8 clean arrivals -> pcount saturates at 7, full=1; the 8th arrival gives one arr_drop pulse and index_rom=5'b01111 (wtime=21). tcount_load with tcount_in=3 -> index_rom=5'b11111, wtime=9.
- Back and front debounced falls in the same cycle at pcount=7, then again at pcount=0 -> pcount unchanged, no arr_drop or dep_err. Front-only fall at pcount=0 -> dep_err pulse, pcount stays 0.
- 3-cycle glitch on front_sensor at pcount=4 -> no departure, pcount=4. tcount_load with tcount_in=0 -> tcount unchanged.
- Assert rst asynchronously between clocks while back_sensor debounce is in progress at pcount=5 -> outputs return to reset values immediately. After release, the stale sensor transition produces no count.

Source files
------------

// File: rtl/queue_ctrl_if.sv
// queue_ctrl_if: sensor, teller-load, wait-time ROM and status signals of the bank queue controller
interface queue_ctrl_if;
    logic       back_sensor;
    logic       front_sensor;
    logic [1:0] tcount_in;
    logic       tcount_load;
    logic [4:0] wtime_rom;
    logic [4:0] index_rom;
    logic [2:0] pcount;
    logic [1:0] tcount;
    logic [4:0] wtime;
    logic       full;
    logic       empty;
    logic       arr_drop;
    logic       dep_err;
    modport master (
        output back_sensor, front_sensor, tcount_in, tcount_load, wtime_rom,
        input  index_rom, pcount, tcount, wtime, full, empty, arr_drop, dep_err
    );
    modport slave (
        input  back_sensor, front_sensor, tcount_in, tcount_load, wtime_rom,
        output index_rom, pcount, tcount, wtime, full, empty, arr_drop, dep_err
    );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl: debounces queue entry/exit photocells, tracks queued people and tellers, registers ROM wait time
module queue_ctrl #(
    parameter int         DEB_CYCLES = 4,
    parameter logic [1:0] TCOUNT_RST = 2'd1
) (
    input logic         clk,
    input logic         rst,
    queue_ctrl_if.slave q
);
    // bit 0 = back (arrival) sensor, bit 1 = front (departure) sensor
    logic [1:0]      s1, s2, deb, hist;
    logic [1:0][7:0] cnt;
    logic [2:0]      pcount;
    logic [1:0]      tcount;
    logic [4:0]      wtime;
    logic            arr_drop, dep_err, arr, dep;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            deb  <= '0;
            hist <= '0;
            cnt  <= '0;
        end else begin
            s1   <= {q.front_sensor, q.back_sensor};
            s2   <= s1;
            hist <= deb;
            for (int j = 0; j < 2; j++)
                if (s2[j] == deb[j]) cnt[j] <= '0;
                else if (cnt[j] == 8'(DEB_CYCLES - 1)) begin
                    deb[j] <= s2[j];
                    cnt[j] <= '0;
                end else cnt[j] <= cnt[j] + 8'd1;
        end
    end
    // a person is counted once the beam clears, i.e. on the debounced falling edge
    assign arr = hist[0] & ~deb[0];
    assign dep = hist[1] & ~deb[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcount   <= '0;
            tcount   <= TCOUNT_RST;
            wtime    <= '0;
            arr_drop <= 1'b0;
            dep_err  <= 1'b0;
        end else begin
            arr_drop <= arr & ~dep & (pcount == 3'd7);
            dep_err  <= dep & ~arr & (pcount == 3'd0);
            if (arr && !dep && pcount != 3'd7) pcount <= pcount + 3'd1;
            else if (dep && !arr && pcount != 3'd0) pcount <= pcount - 3'd1;
            if (q.tcount_load && q.tcount_in != 2'd0) tcount <= q.tcount_in;
            wtime <= q.wtime_rom;
        end
    end
    assign q.index_rom = {tcount, pcount};
    assign q.pcount    = pcount;
    assign q.tcount    = tcount;
    assign q.wtime     = wtime;
    assign q.full      = pcount == 3'd7;
    assign q.empty     = pcount == 3'd0;
    assign q.arr_drop  = arr_drop;
    assign q.dep_err   = dep_err;
endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: directed scenario tests for queue_ctrl with a wait-time ROM model attached
module tb_queue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_n = 0, total_n = 0;
    int   arr_n = 0, dep_n = 0;
    int   a0, d0;

    queue_ctrl_if qi();
    queue_ctrl #(.DEB_CYCLES(4), .TCOUNT_RST(2'd1)) dut (.clk(clk), .rst(rst), .q(qi.slave));

    always #5 clk = ~clk;

    // ROM: 3 minutes per person per teller, rounded up; 0 when the queue is empty
    function automatic logic [4:0] rom(input logic [4:0] idx);
        int tc, p;
        tc = int'(idx[4:3]);
        p  = int'(idx[2:0]);
        return (tc == 0) ? 5'd0 : 5'(3 * ((p + tc - 1) / tc));
    endfunction
    assign qi.wtime_rom = rom(qi.index_rom);

    always @(negedge clk) begin
        if (qi.arr_drop) arr_n++;
        if (qi.dep_err) dep_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic b, input logic f);
        qi.back_sensor  = b;
        qi.front_sensor = f;
        repeat (10) tick();
        qi.back_sensor  = 1'b0;
        qi.front_sensor = 1'b0;
        repeat (10) tick();
    endtask

    task automatic load_tellers(input logic [1:0] t);
        qi.tcount_in   = t;
        qi.tcount_load = 1'b1;
        tick();
        qi.tcount_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total_n++; if (qi.pcount !== 3'd0) $display("FAIL rst_pcount: got %0d want 0", qi.pcount); else pass_n++;
        total_n++; if (qi.tcount !== 2'd1) $display("FAIL rst_tcount: got %0d want 1", qi.tcount); else pass_n++;
        total_n++; if (qi.index_rom !== 5'b01000) $display("FAIL rst_index: got %b want 01000", qi.index_rom); else pass_n++;
        total_n++; if (qi.wtime !== 5'd0) $display("FAIL rst_wtime: got %0d want 0", qi.wtime); else pass_n++;
        total_n++; if (qi.empty !== 1'b1 || qi.full !== 1'b0) $display("FAIL rst_flags: got empty=%b full=%b want 1 0", qi.empty, qi.full); else pass_n++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_arrival_latency();
        qi.back_sensor = 1'b1;
        repeat (10) tick();
        qi.back_sensor = 1'b0;
        repeat (6) tick();
        total_n++; if (qi.pcount !== 3'd0) $display("FAIL lat_early: got %0d want 0", qi.pcount); else pass_n++;
        tick();
        total_n++; if (qi.pcount !== 3'd1) $display("FAIL lat_pcount: got %0d want 1", qi.pcount); else pass_n++;
        total_n++; if (qi.index_rom !== 5'b01001) $display("FAIL lat_index: got %b want 01001", qi.index_rom); else pass_n++;
        total_n++; if (qi.wtime !== 5'd0) $display("FAIL lat_wtime_lag: got %0d want 0", qi.wtime); else pass_n++;
        tick();
        total_n++; if (qi.wtime !== 5'd3) $display("FAIL lat_wtime: got %0d want 3", qi.wtime); else pass_n++;
    endtask

    task automatic test_saturation();
        a0 = arr_n;
        repeat (6) pulse(1'b1, 1'b0);
        total_n++; if (qi.pcount !== 3'd7 || qi.full !== 1'b1) $display("FAIL sat_full: got pcount=%0d full=%b want 7 1", qi.pcount, qi.full); else pass_n++;
        total_n++; if (arr_n - a0 !== 0) $display("FAIL sat_no_drop: got %0d drops want 0", arr_n - a0); else pass_n++;
        total_n++; if (qi.index_rom !== 5'b01111 || qi.wtime !== 5'd21) $display("FAIL sat_wtime: got index=%b wtime=%0d want 01111 21", qi.index_rom, qi.wtime); else pass_n++;
        pulse(1'b1, 1'b0);
        total_n++; if (arr_n - a0 !== 1) $display("FAIL sat_drop: got %0d drops want 1", arr_n - a0); else pass_n++;
        total_n++; if (qi.pcount !== 3'd7) $display("FAIL sat_hold: got %0d want 7", qi.pcount); else pass_n++;
        load_tellers(2'd3);
        total_n++; if (qi.tcount !== 2'd3 || qi.index_rom !== 5'b11111) $display("FAIL tload: got tcount=%0d index=%b want 3 11111", qi.tcount, qi.index_rom); else pass_n++;
        total_n++; if (qi.wtime !== 5'd21) $display("FAIL tload_lag: got %0d want 21", qi.wtime); else pass_n++;
        tick();
        total_n++; if (qi.wtime !== 5'd9) $display("FAIL tload_wtime: got %0d want 9", qi.wtime); else pass_n++;
    endtask

    task automatic test_simultaneous();
        a0 = arr_n;
        d0 = dep_n;
        pulse(1'b1, 1'b1);
        total_n++; if (qi.pcount !== 3'd7) $display("FAIL both_full: got %0d want 7", qi.pcount); else pass_n++;
        total_n++; if (arr_n != a0 || dep_n != d0) $display("FAIL both_full_err: got drops=%0d errs=%0d want 0 0", arr_n - a0, dep_n - d0); else pass_n++;
        repeat (7) pulse(1'b0, 1'b1);
        total_n++; if (qi.pcount !== 3'd0 || qi.empty !== 1'b1 || qi.wtime !== 5'd0) $display("FAIL drain: got pcount=%0d empty=%b wtime=%0d want 0 1 0", qi.pcount, qi.empty, qi.wtime); else pass_n++;
        pulse(1'b1, 1'b1);
        total_n++; if (qi.pcount !== 3'd0) $display("FAIL both_empty: got %0d want 0", qi.pcount); else pass_n++;
        total_n++; if (arr_n != a0 || dep_n != d0) $display("FAIL both_empty_err: got drops=%0d errs=%0d want 0 0", arr_n - a0, dep_n - d0); else pass_n++;
        pulse(1'b0, 1'b1);
        total_n++; if (dep_n - d0 !== 1) $display("FAIL dep_err: got %0d pulses want 1", dep_n - d0); else pass_n++;
        total_n++; if (qi.pcount !== 3'd0) $display("FAIL dep_err_hold: got %0d want 0", qi.pcount); else pass_n++;
    endtask

    task automatic test_glitch();
        repeat (4) pulse(1'b1, 1'b0);
        total_n++; if (qi.pcount !== 3'd4) $display("FAIL glitch_setup: got %0d want 4", qi.pcount); else pass_n++;
        d0 = dep_n;
        qi.front_sensor = 1'b1;
        repeat (3) tick();
        qi.front_sensor = 1'b0;
        repeat (15) tick();
        total_n++; if (qi.pcount !== 3'd4 || dep_n != d0) $display("FAIL glitch: got pcount=%0d errs=%0d want 4 0", qi.pcount, dep_n - d0); else pass_n++;
        load_tellers(2'd0);
        tick();
        total_n++; if (qi.tcount !== 2'd3) $display("FAIL tload_zero: got %0d want 3", qi.tcount); else pass_n++;
    endtask

    task automatic test_async_reset();
        pulse(1'b1, 1'b0);
        total_n++; if (qi.pcount !== 3'd5) $display("FAIL ares_setup: got %0d want 5", qi.pcount); else pass_n++;
        a0 = arr_n;
        qi.back_sensor = 1'b1;
        repeat (10) tick();
        qi.back_sensor = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        total_n++; if (qi.pcount !== 3'd0 || qi.empty !== 1'b1) $display("FAIL ares_pcount: got pcount=%0d empty=%b want 0 1", qi.pcount, qi.empty); else pass_n++;
        total_n++; if (qi.tcount !== 2'd1 || qi.index_rom !== 5'b01000) $display("FAIL ares_tcount: got tcount=%0d index=%b want 1 01000", qi.tcount, qi.index_rom); else pass_n++;
        total_n++; if (qi.wtime !== 5'd0) $display("FAIL ares_wtime: got %0d want 0", qi.wtime); else pass_n++;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        total_n++; if (qi.pcount !== 3'd0 || arr_n != a0) $display("FAIL ares_stale: got pcount=%0d drops=%0d want 0 0", qi.pcount, arr_n - a0); else pass_n++;
    endtask

    initial begin
        qi.back_sensor  = 1'b0;
        qi.front_sensor = 1'b0;
        qi.tcount_in    = 2'd0;
        qi.tcount_load  = 1'b0;
        test_reset();
        test_arrival_latency();
        test_saturation();
        test_simultaneous();
        test_glitch();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
